// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel integer clock divider running entirely on clk.
// Each channel divides by a runtime-programmable N (odd or even, 2..2^CNT_W-1).
// y is the registered AND of the channels selected by AND_MASK.
// Optional feature: define CLK_DIV_MULTI_TICK_EN to add a per-channel `tick`
// output that pulses for one cycle at the start of every period.
module clk_div_multi #(
  parameter int                NUM_CH   = 4,
  parameter int                CNT_W    = 8,
  parameter int                DIV_INIT = 2,
  parameter logic [NUM_CH-1:0] AND_MASK = NUM_CH'(4'b0101),
  localparam int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync_start,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] clk_out,
  output logic              y
`ifdef CLK_DIV_MULTI_TICK_EN
  ,
  output logic [NUM_CH-1:0] tick
`endif
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_INIT);

  // Per-channel state. A channel is idle (live=0, armed=0), arming for one
  // cycle after ch_en is first seen (armed=1), or running (live=1).
  logic [NUM_CH-1:0][CNT_W-1:0] cnt;
  logic [NUM_CH-1:0][CNT_W-1:0] div;
  logic [NUM_CH-1:0][CNT_W-1:0] shadow;
  logic [NUM_CH-1:0]            pending;
  logic [NUM_CH-1:0]            live;
  logic [NUM_CH-1:0]            armed;

  logic [NUM_CH-1:0]            accept;
  logic [NUM_CH-1:0]            restart;
  logic [NUM_CH-1:0]            wrap;
  logic [NUM_CH-1:0]            apply;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_inc;
  logic [NUM_CH-1:0][CNT_W:0]   hi;
  logic [CNT_W-1:0]             cfg_div_clamped;

  // Divisors below 2 cannot make a square wave; store them as 2.
  assign cfg_div_clamped = (cfg_div < CNT_W'(2)) ? CNT_W'(2) : cfg_div;

  // Update handshake: a transfer happens on a rising edge where cfg_valid and
  // cfg_ready are both high. cfg_ready is low while the addressed channel
  // still holds an unapplied divisor in its shadow register; the requester
  // must hold cfg_valid/cfg_ch/cfg_div until the transfer happens.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == cfg_ch) cfg_ready = ~pending[i];
    end
  end

  // Per-channel event decode: accept, restart, period wrap, shadow apply.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      accept[i]  = cfg_valid && !pending[i] && (CH_W'(i) == cfg_ch);
      restart[i] = ch_en[i] && (sync_start || armed[i]);
      wrap[i]    = ch_en[i] && live[i] && !restart[i] &&
                   (cnt[i] == div[i] - CNT_W'(1));
      // A new divisor only lands at a period boundary or when the channel
      // is not producing a period, so no truncated/stretched period occurs.
      apply[i]   = pending[i] && (!ch_en[i] || restart[i] || !live[i] || wrap[i]);
      cnt_inc[i] = cnt[i] + CNT_W'(1);
      hi[i]      = ({1'b0, div[i]} + (CNT_W+1)'(1)) >> 1;
    end
  end

  // Channel counters, divisor/shadow registers and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt[i]    <= '0;
        div[i]    <= DIV_RST;
        shadow[i] <= DIV_RST;
      end
      pending <= '0;
      live    <= '0;
      armed   <= '0;
      clk_out <= '0;
`ifdef CLK_DIV_MULTI_TICK_EN
      tick    <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (apply[i]) begin
          div[i]     <= shadow[i];
          pending[i] <= 1'b0;
        end else if (accept[i]) begin
          shadow[i]  <= cfg_div_clamped;
          pending[i] <= 1'b1;
        end

        if (!ch_en[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          live[i]    <= 1'b0;
          armed[i]   <= 1'b0;
        end else if (restart[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b1;
          live[i]    <= 1'b1;
          armed[i]   <= 1'b0;
        end else if (!live[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b0;
          armed[i]   <= 1'b1;
        end else if (wrap[i]) begin
          cnt[i]     <= '0;
          clk_out[i] <= 1'b1;
        end else begin
          cnt[i]     <= cnt_inc[i];
          clk_out[i] <= ({1'b0, cnt_inc[i]} < hi[i]);
        end

`ifdef CLK_DIV_MULTI_TICK_EN
        tick[i] <= restart[i] | wrap[i];
`endif
      end
    end
  end

  // Combined output: high one cycle after every selected channel is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y <= 1'b0;
    end else begin
      y <= (AND_MASK != '0) && (&(clk_out | ~AND_MASK));
    end
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Testbench for clk_div_multi: directed stimulus, a period-level reference
// model checked every cycle, and literal expectations pinning key cycles.
module tb_clk_div_multi;

  localparam int         NUM_CH   = 4;
  localparam int         CNT_W    = 8;
  localparam logic [3:0] AND_MASK = 4'b0101;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ch_en = '0;
  logic       sync_start = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic [3:0] clk_out;
  logic       y;
`ifdef CLK_DIV_MULTI_TICK_EN
  logic [3:0] tick;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clk_div_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .DIV_INIT(2), .AND_MASK(AND_MASK)
  ) dut (
    .clk(clk), .reset(reset), .ch_en(ch_en), .sync_start(sync_start),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_div(cfg_div), .clk_out(clk_out), .y(y)
`ifdef CLK_DIV_MULTI_TICK_EN
    , .tick(tick)
`endif
  );

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each channel is described by when its current period started (t0) and its
  // period length N: level = (edges since period start) < ceil(N/2).
  int         edge_n = 0;
  int         m_on[4];   // 0 off, 1 waiting one edge to start, 2 running
  int         m_t0[4];
  int         m_n[4];
  int         m_sh[4];
  bit         m_pend[4];
  logic [3:0] exp_clk = '0;
  logic [3:0] exp_tick = '0;
  logic       exp_y = 1'b0;

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_on[c] = 0; m_t0[c] = 0; m_n[c] = 2; m_sh[c] = 2; m_pend[c] = 0;
    end
    exp_clk = '0; exp_tick = '0; exp_y = 1'b0;
  endtask

  task automatic model_step();
    int e, acc_ch, acc_div;
    bit acc, take;
    edge_n++;
    e = edge_n;
    exp_y   = (AND_MASK != 0) && ((exp_clk & AND_MASK) == AND_MASK);
    acc_ch  = int'(cfg_ch);
    acc     = cfg_valid && !m_pend[acc_ch];
    acc_div = (cfg_div < 2) ? 2 : int'(cfg_div);
    exp_tick = '0;
    for (int c = 0; c < 4; c++) begin
      take = 0;
      if (!ch_en[c]) begin
        m_on[c] = 0; exp_clk[c] = 1'b0; take = 1;
      end else if (sync_start || m_on[c] == 1) begin
        m_on[c] = 2; m_t0[c] = e; exp_tick[c] = 1'b1; take = 1;
      end else if (m_on[c] == 0) begin
        m_on[c] = 1; exp_clk[c] = 1'b0; take = 1;
      end else if (e - m_t0[c] == m_n[c]) begin
        m_t0[c] = e; exp_tick[c] = 1'b1; take = 1;
      end
      if (take && m_pend[c]) begin
        m_n[c] = m_sh[c]; m_pend[c] = 0;
      end
      if (m_on[c] == 2) exp_clk[c] = ((e - m_t0[c]) < (m_n[c] + 1) / 2);
    end
    if (acc) begin
      m_sh[acc_ch] = acc_div; m_pend[acc_ch] = 1;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) model_reset();
    else        model_step();
  end

  // Every-cycle comparison, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      check("clk_out", clk_out, exp_clk);
      check("y", y, exp_y);
      check("cfg_ready", cfg_ready, !m_pend[cfg_ch]);
`ifdef CLK_DIV_MULTI_TICK_EN
      check("tick", tick, exp_tick);
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic cfg_drive(input logic [1:0] ch, input logic [7:0] dv);
    cfg_valid = 1'b1; cfg_ch = ch; cfg_div = dv;
  endtask

  logic [9:0] pat1;
  logic [3:0] t4 [5];

  initial begin
    // Reset state
    #1 reset = 1'b0;
    #1;
    check("rst_clk_out", clk_out, 4'h0);
    check("rst_y", y, 1'b0);
    check("rst_ready", cfg_ready, 1'b1);
    nxt(); nxt();

    // T1: N=2 everywhere, all channels enabled
    reset = 1'b1; ch_en = 4'hF;
    nxt(); check("t1_arm", clk_out, 4'h0);
    nxt(); check("t1_on", clk_out, 4'hF); check("t1_y0", y, 1'b0);
`ifdef CLK_DIV_MULTI_TICK_EN
    check("t7_tick_start", tick, 4'hF);
`endif
    nxt(); check("t1_off", clk_out, 4'h0); check("t1_y1", y, 1'b1);
`ifdef CLK_DIV_MULTI_TICK_EN
    check("t7_tick_low", tick, 4'h0);
`endif
    nxt(); check("t1_on2", clk_out, 4'hF); check("t1_y2", y, 1'b0);

    // T2/T3: ch1 to N=5 mid-period, second request rejected while pending
    cfg_drive(2'd1, 8'd5);
    #1 check("t2_ready", cfg_ready, 1'b1);
    nxt(); check("t2_cur_period", clk_out[1], 1'b0);
    cfg_div = 8'd7;
    #1 check("t3_busy", cfg_ready, 1'b0);
    nxt();
    cfg_valid = 1'b0;
    #1 check("t3_ready_back", cfg_ready, 1'b1);
    pat1 = 10'b1110011100;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) nxt();
      check("t2_ch1_wave", clk_out[1], pat1[9-k]);
    end

    // T4: N=3,4,7 on ch0..2 then sync_start
    nxt(); cfg_drive(2'd0, 8'd3);
    nxt(); cfg_drive(2'd1, 8'd4);
    nxt(); cfg_drive(2'd2, 8'd7);
    nxt(); cfg_valid = 1'b0; sync_start = 1'b1;
    nxt(); sync_start = 1'b0;
    t4[0] = 4'hF; t4[1] = 4'h7; t4[2] = 4'hC; t4[3] = 4'h5; t4[4] = 4'hB;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) nxt();
      check("t4_sync_wave", clk_out, t4[k]);
    end

    // T5: clamps (1 and 0 -> 2), N=255, disable beats sync on ch3
    nxt(); cfg_drive(2'd0, 8'd1);
    nxt(); cfg_drive(2'd2, 8'd0);
    nxt(); cfg_drive(2'd1, 8'd255);
    nxt(); cfg_valid = 1'b0; sync_start = 1'b1; ch_en = 4'b0111;
    nxt(); sync_start = 1'b0;
    check("t5_sync", clk_out, 4'h7);
    for (int k = 1; k <= 255; k++) begin
      nxt();
      if (k == 1)   check("t5_clamp_fall", clk_out[2:0], 3'b010);
      if (k == 2)   check("t5_clamp_rise", {clk_out[2], clk_out[0]}, 2'b11);
      if (k == 10)  cfg_drive(2'd3, 8'd3);
      if (k == 11) begin
        cfg_valid = 1'b0;
        #1 check("t5_dis_pending", cfg_ready, 1'b0);
      end
      if (k == 12) begin
        #1 check("t5_dis_applied", cfg_ready, 1'b1);
      end
      if (k == 127) check("t5_n255_hi_end", clk_out[1], 1'b1);
      if (k == 128) check("t5_n255_lo_start", clk_out[1], 1'b0);
      if (k == 254) check("t5_n255_lo_end", clk_out[1], 1'b0);
      if (k == 255) check("t5_n255_rise", clk_out[1], 1'b1);
    end

    // T6: reset mid-period with an update pending on ch1
    cfg_drive(2'd1, 8'd9);
    nxt(); cfg_valid = 1'b0;
    #1 check("t6_pending", cfg_ready, 1'b0);
    #2 reset = 1'b0;
    #1;
    check("t6_async_clk", clk_out, 4'h0);
    check("t6_async_y", y, 1'b0);
    check("t6_async_ready", cfg_ready, 1'b1);
    nxt(); nxt();
    reset = 1'b1;
    nxt(); check("t6_arm", clk_out, 4'h0);
    nxt(); check("t6_on", clk_out, 4'h7);
    nxt(); check("t6_off", clk_out, 4'h0);
    nxt(); check("t6_on2", clk_out, 4'h7);
    nxt();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
